// File: rtl/il1_fill_controller_if.sv
// L2 line-request / beat-return channel between the IL1 fill controller
// and the L2 cache.
interface il1_fill_controller_if #(
  parameter int PC_W   = 32,
  parameter int INST_W = 32
);
  logic              l2_req_valid;
  logic              l2_req_ready;
  logic [PC_W-1:0]   l2_req_addr;
  logic              l2_rsp_valid;
  logic [INST_W-1:0] l2_rsp_data;

  modport master (
    output l2_req_valid,
    output l2_req_addr,
    input  l2_req_ready,
    input  l2_rsp_valid,
    input  l2_rsp_data
  );

  modport slave (
    input  l2_req_valid,
    input  l2_req_addr,
    output l2_req_ready,
    output l2_rsp_valid,
    output l2_rsp_data
  );
endinterface

// File: rtl/il1_fill_controller.sv
// IL1 miss/fill controller: critical-word-first line fill with early
// restart from the fill buffer, plus L2 back-invalidation handling.
module il1_fill_controller #(
  parameter int          PC_W        = 32,
  parameter int          INST_W      = 32,
  parameter int          WAYS        = 4,
  parameter int          LINE_WORDS  = 4,
  parameter int          INDEX_W     = 6,
  parameter logic [31:0] BUBBLE_INST = 32'h00007033
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [PC_W-1:0]    pc,
  input  logic               pc_valid,
  input  logic               l1_hit,
  input  logic               vc_hit,
  input  logic [INST_W-1:0]  l1_inst,
  input  logic [INST_W-1:0]  vc_inst,
  input  logic [WAYS-1:0]    victim_way,
  input  logic [WAYS-1:0]    ways_valid,
  output logic [INST_W-1:0]  inst,
  output logic               inst_valid,
  output logic               halt,
  il1_fill_controller_if.master l2,
  output logic               fill_we,
  output logic [WAYS-1:0]    fill_way,
  output logic [PC_W-1:0]    fill_addr,
  output logic [INST_W-1:0]  fill_data,
  output logic               vc_evict,
  input  logic               binv_req,
  input  logic [INDEX_W-1:0] binv_index,
  input  logic [WAYS-1:0]    binv_way_hit,
  output logic               lookup_sel,
  output logic [INDEX_W-1:0] lookup_index,
  output logic [WAYS-1:0]    clear_way,
  output logic               binv_ack
);

  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam int TAG_W = PC_W - OFF_W - 2;

  typedef enum logic [1:0] {
    M_IDLE, M_REQ, M_FILL, M_DONE
  } mstate_t;

  typedef enum logic [2:0] {
    B_IDLE, B_LOOK, B_CLR, B_ACK, B_WAIT
  } bstate_t;

  mstate_t ms, ms_nx;
  bstate_t bs, bs_nx;

  logic [TAG_W-1:0]      miss_tag;
  logic [OFF_W-1:0]      crit;
  logic [OFF_W-1:0]      beat;
  logic [WAYS-1:0]       miss_way;
  logic [LINE_WORDS-1:0] mask;
  logic [INST_W-1:0]     fbuf [LINE_WORDS];
  logic [INDEX_W-1:0]    idx_q;

  logic [TAG_W-1:0] pc_tag;
  logic [OFF_W-1:0] pc_word;
  logic [OFF_W-1:0] beat_word;
  logic             miss_det;
  logic             miss_start;
  logic             binv_busy;
  logic             binv_start;
  logic             line_hit;
  logic             buf_hit;
  logic             beat_hit;
  logic             unused;

  assign pc_tag    = pc[PC_W-1:OFF_W+2];
  assign pc_word   = pc[OFF_W+1:2];
  assign beat_word = crit + beat;
  assign unused    = ^pc[1:0];

  // A pending or starting back-invalidate owns the tag port, so it wins.
  assign binv_busy  = binv_req | (bs != B_IDLE);
  assign miss_det   = pc_valid & ~l1_hit & ~vc_hit;
  assign miss_start = (ms == M_IDLE) & miss_det & ~binv_busy;
  assign binv_start = (bs == B_IDLE) & binv_req &
                      ((ms == M_IDLE) | (ms == M_REQ));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ms <= M_IDLE;
      bs <= B_IDLE;
    end else begin
      ms <= ms_nx;
      bs <= bs_nx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      miss_tag <= '0;
      crit     <= '0;
      beat     <= '0;
      miss_way <= '0;
      mask     <= '0;
      idx_q    <= '0;
    end else begin
      if (miss_start) begin
        miss_tag <= pc_tag;
        crit     <= pc_word;
        miss_way <= victim_way;
        beat     <= '0;
      end else if (fill_we) begin
        beat <= beat + 1'b1;
      end
      if (ms == M_DONE)
        mask <= '0;
      else if (fill_we)
        mask[beat_word] <= 1'b1;
      if (binv_start)
        idx_q <= binv_index;
    end
  end

  always_ff @(posedge clk) begin
    if (fill_we)
      fbuf[beat_word] <= l2.l2_rsp_data;
  end

  always_comb begin
    ms_nx           = ms;
    l2.l2_req_valid = 1'b0;
    fill_we         = 1'b0;
    vc_evict        = 1'b0;
    unique case (ms)
      M_IDLE: begin
        if (miss_start) begin
          ms_nx    = M_REQ;
          vc_evict = &ways_valid;
        end
      end
      M_REQ: begin
        l2.l2_req_valid = 1'b1;
        if (l2.l2_req_ready)
          ms_nx = M_FILL;
      end
      M_FILL: begin
        if (l2.l2_rsp_valid) begin
          fill_we = 1'b1;
          if (&beat)
            ms_nx = M_DONE;
        end
      end
      M_DONE: ms_nx = M_IDLE;
      default: ms_nx = M_IDLE;
    endcase
  end

  always_comb begin
    bs_nx      = bs;
    lookup_sel = 1'b0;
    clear_way  = '0;
    binv_ack   = 1'b0;
    unique case (bs)
      B_IDLE: if (binv_start) bs_nx = B_LOOK;
      B_LOOK: begin
        lookup_sel = 1'b1;
        bs_nx      = B_CLR;
      end
      B_CLR: begin
        lookup_sel = 1'b1;
        clear_way  = binv_way_hit;
        bs_nx      = B_ACK;
      end
      B_ACK: begin
        binv_ack = 1'b1;
        bs_nx    = B_WAIT;
      end
      B_WAIT: if (!binv_req) bs_nx = B_IDLE;
      default: bs_nx = B_IDLE;
    endcase
  end

  assign l2.l2_req_addr = {miss_tag, crit, 2'b00};
  assign fill_addr      = {miss_tag, beat_word, 2'b00};
  assign fill_data      = l2.l2_rsp_data;
  assign fill_way       = fill_we ? miss_way : '0;
  assign lookup_index   = idx_q;

  // The beat arriving this cycle forwards straight to fetch.
  assign line_hit = (pc_tag == miss_tag);
  assign buf_hit  = line_hit & mask[pc_word];
  assign beat_hit = fill_we & line_hit & (beat_word == pc_word);

  always_comb begin
    inst       = INST_W'(BUBBLE_INST);
    inst_valid = 1'b1;
    if (beat_hit)
      inst = l2.l2_rsp_data;
    else if (buf_hit)
      inst = fbuf[pc_word];
    else if (l1_hit)
      inst = l1_inst;
    else if (vc_hit)
      inst = vc_inst;
    else
      inst_valid = 1'b0;
  end

  assign halt = pc_valid & ~inst_valid;

endmodule

// File: tb/tb_il1_fill_controller.sv
// Randomized self-checking bench for il1_fill_controller against a
// line-level model of the miss, fill and back-invalidate behaviour.
module tb_il1_fill_controller;

  localparam logic [31:0] BUBBLE = 32'h00007033;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc;
  logic        pc_valid;
  logic        l1_hit;
  logic        vc_hit;
  logic [31:0] l1_inst;
  logic [31:0] vc_inst;
  logic [3:0]  victim_way;
  logic [3:0]  ways_valid;
  logic [31:0] inst;
  logic        inst_valid;
  logic        halt;
  logic        fill_we;
  logic [3:0]  fill_way;
  logic [31:0] fill_addr;
  logic [31:0] fill_data;
  logic        vc_evict;
  logic        binv_req;
  logic [5:0]  binv_index;
  logic [3:0]  binv_way_hit;
  logic        lookup_sel;
  logic [5:0]  lookup_index;
  logic [3:0]  clear_way;
  logic        binv_ack;

  int checks = 0;
  int errors = 0;

  il1_fill_controller_if l2_if ();

  il1_fill_controller dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pc           (pc),
    .pc_valid     (pc_valid),
    .l1_hit       (l1_hit),
    .vc_hit       (vc_hit),
    .l1_inst      (l1_inst),
    .vc_inst      (vc_inst),
    .victim_way   (victim_way),
    .ways_valid   (ways_valid),
    .inst         (inst),
    .inst_valid   (inst_valid),
    .halt         (halt),
    .l2           (l2_if),
    .fill_we      (fill_we),
    .fill_way     (fill_way),
    .fill_addr    (fill_addr),
    .fill_data    (fill_data),
    .vc_evict     (vc_evict),
    .binv_req     (binv_req),
    .binv_index   (binv_index),
    .binv_way_hit (binv_way_hit),
    .lookup_sel   (lookup_sel),
    .lookup_index (lookup_index),
    .clear_way    (clear_way),
    .binv_ack     (binv_ack)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_idle();
    pc_valid = 1'b0;
    l1_hit   = 1'b0;
    vc_hit   = 1'b0;
    pc       = $urandom & 32'hFFFF_FFFC;
    @(negedge clk);
    check("idle_inst", inst, BUBBLE);
    check("idle_valid", {31'd0, inst_valid}, 0);
    check("idle_halt", {31'd0, halt}, 0);
    tick();
  endtask

  task automatic do_hit(input logic l1, input logic vc,
                        input logic [31:0] d1, input logic [31:0] d2);
    pc       = $urandom & 32'hFFFF_FFFC;
    pc_valid = 1'b1;
    l1_hit   = l1;
    vc_hit   = vc;
    l1_inst  = d1;
    vc_inst  = d2;
    @(negedge clk);
    check("hit_inst", inst, l1 ? d1 : d2);
    check("hit_valid", {31'd0, inst_valid}, 1);
    check("hit_halt", {31'd0, halt}, 0);
    check("hit_noreq", {31'd0, l2_if.l2_req_valid}, 0);
    check("hit_noevict", {31'd0, vc_evict}, 0);
    tick();
    pc_valid = 1'b0;
    l1_hit   = 1'b0;
    vc_hit   = 1'b0;
  endtask

  task automatic do_binv(input logic [5:0] idx, input logic [3:0] hw,
                         input bit miss_wait);
    logic [31:0] exp_sel [5];
    logic [31:0] exp_clr [5];
    logic [31:0] exp_ack [5];
    exp_sel = '{0, 1, 1, 0, 0};
    exp_clr = '{0, 0, 32'(hw), 0, 0};
    exp_ack = '{0, 0, 0, 1, 0};
    binv_req     = 1'b1;
    binv_index   = idx;
    binv_way_hit = hw;
    for (int ph = 0; ph < 5; ph++) begin
      if (ph == 4) binv_req = 1'b0;
      @(negedge clk);
      check("binv_sel", {31'd0, lookup_sel}, exp_sel[ph]);
      check("binv_clr", {28'd0, clear_way}, exp_clr[ph]);
      check("binv_ack", {31'd0, binv_ack}, exp_ack[ph]);
      if (ph == 1 || ph == 2)
        check("binv_idx", {26'd0, lookup_index}, {26'd0, idx});
      if (miss_wait) begin
        check("binv_halt", {31'd0, halt}, 1);
        check("binv_noreq", {31'd0, l2_if.l2_req_valid}, 0);
        check("binv_noevict", {31'd0, vc_evict}, 0);
      end
      tick();
      if (ph == 0) binv_index = 6'($urandom);
    end
  endtask

  task automatic do_miss(input logic [31:0] mpc, input logic [3:0] wv,
                         input logic [3:0] vw, input int rdly,
                         input int nbeats, input int binv_at);
    logic [31:0] base, data, fpc, lq [4];
    logic [1:0]  crit, bw, w;
    bit          filled [4];
    bit          rv, inl, ev;
    int          k, cyc;
    base = mpc & 32'hFFFF_FFF0;
    crit = mpc[3:2];
    for (int i = 0; i < 4; i++) begin
      filled[i] = 1'b0;
      lq[i]     = '0;
    end
    pc         = mpc;
    pc_valid   = 1'b1;
    l1_hit     = 1'b0;
    vc_hit     = 1'b0;
    ways_valid = wv;
    victim_way = vw;
    @(negedge clk);
    check("miss_halt", {31'd0, halt}, 1);
    check("miss_evict", {31'd0, vc_evict}, {31'd0, &wv});
    check("miss_noreq", {31'd0, l2_if.l2_req_valid}, 0);
    tick();
    ways_valid = 4'($urandom);
    victim_way = ~vw;
    for (int d = 0; d <= rdly; d++) begin
      l2_if.l2_req_ready = (d == rdly);
      @(negedge clk);
      check("req_valid", {31'd0, l2_if.l2_req_valid}, 1);
      check("req_addr", l2_if.l2_req_addr, mpc);
      check("req_nofill", {31'd0, fill_we}, 0);
      check("req_noevict", {31'd0, vc_evict}, 0);
      check("req_halt", {31'd0, halt}, 1);
      tick();
    end
    l2_if.l2_req_ready = 1'b0;
    k   = 0;
    cyc = 0;
    while (k < nbeats) begin
      if (k == binv_at) binv_req = 1'b1;
      rv   = (cyc > 20) || ($urandom_range(0, 2) != 0);
      data = $urandom;
      l2_if.l2_rsp_valid = rv;
      l2_if.l2_rsp_data  = data;
      if (k == 0)
        fpc = mpc;
      else if ($urandom_range(0, 7) == 0)
        fpc = mpc ^ 32'h40;
      else
        fpc = base | 32'($urandom_range(0, 3) << 2);
      pc  = fpc;
      inl = (fpc[31:4] == mpc[31:4]);
      w   = fpc[3:2];
      bw  = crit + 2'(k);
      ev  = inl && (filled[w] || (rv && bw == w));
      @(negedge clk);
      check("fill_we", {31'd0, fill_we}, {31'd0, rv});
      if (rv) begin
        check("fill_addr", fill_addr, base | 32'({bw, 2'b00}));
        check("fill_way", {28'd0, fill_way}, {28'd0, vw});
        check("fill_data", fill_data, data);
      end else begin
        check("fill_way0", {28'd0, fill_way}, 0);
      end
      check("er_valid", {31'd0, inst_valid}, {31'd0, ev});
      check("er_halt", {31'd0, halt}, {31'd0, ~ev});
      if (ev)
        check("er_inst", inst, (rv && bw == w) ? data : lq[w]);
      check("fill_nosel", {31'd0, lookup_sel}, 0);
      tick();
      if (rv) begin
        lq[bw]     = data;
        filled[bw] = 1'b1;
        k++;
      end
      cyc++;
    end
    l2_if.l2_rsp_valid = 1'b0;
    if (nbeats == 4) begin
      pc_valid           = 1'b0;
      l2_if.l2_rsp_valid = 1'b1;
      @(negedge clk);
      check("done_nofill", {31'd0, fill_we}, 0);
      check("done_noreq", {31'd0, l2_if.l2_req_valid}, 0);
      check("done_nosel", {31'd0, lookup_sel}, 0);
      tick();
      l2_if.l2_rsp_valid = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] p;
    rst_n              = 1'b0;
    pc                 = '0;
    pc_valid           = 1'b0;
    l1_hit             = 1'b0;
    vc_hit             = 1'b0;
    l1_inst            = '0;
    vc_inst            = '0;
    victim_way         = 4'b0001;
    ways_valid         = '0;
    binv_req           = 1'b0;
    binv_index         = '0;
    binv_way_hit       = '0;
    l2_if.l2_req_ready = 1'b0;
    l2_if.l2_rsp_valid = 1'b0;
    l2_if.l2_rsp_data  = '0;
    #12;
    check("rst_req", {31'd0, l2_if.l2_req_valid}, 0);
    check("rst_inst", inst, BUBBLE);
    check("rst_valid", {31'd0, inst_valid}, 0);
    check("rst_sel", {31'd0, lookup_sel}, 0);
    check("rst_clr", {28'd0, clear_way}, 0);
    tick();
    rst_n = 1'b1;
    tick();

    do_idle();
    do_hit(1'b1, 1'b0, 32'h00A00093, 32'h0);
    do_hit(1'b1, 1'b1, $urandom, $urandom);
    do_hit(1'b0, 1'b1, $urandom, $urandom);
    do_miss(32'h0000_100C, 4'hF, 4'b0100, 5, 4, -1);
    do_idle();
    do_miss(32'h0000_2000, 4'h7, 4'b0001, 0, 4, -1);

    for (int it = 0; it < 30; it++) begin
      case ($urandom_range(0, 3))
        0: do_hit(1'($urandom), 1'b1, $urandom, $urandom);
        1, 2: do_miss($urandom & 32'hFFFF_FFFC, 4'($urandom),
                      4'(1 << $urandom_range(0, 3)),
                      $urandom_range(0, 3), 4, -1);
        default: do_binv(6'($urandom), 4'($urandom), 1'b0);
      endcase
    end

    do_miss(32'h0000_3008, 4'hF, 4'b1000, 1, 4, 1);
    do_binv(6'h00, 4'b1000, 1'b0);

    p          = 32'h0000_4004;
    pc         = p;
    pc_valid   = 1'b1;
    ways_valid = 4'hF;
    victim_way = 4'b0010;
    do_binv(6'h15, 4'b0010, 1'b1);
    do_miss(p, 4'hF, 4'b0010, 2, 4, -1);

    p = 32'h0000_5004;
    do_miss(p, 4'hF, 4'b0010, 0, 2, -1);
    pc_valid           = 1'b0;
    l2_if.l2_rsp_valid = 1'b1;
    rst_n              = 1'b0;
    #2;
    check("arst_req", {31'd0, l2_if.l2_req_valid}, 0);
    check("arst_fill", {31'd0, fill_we}, 0);
    check("arst_way", {28'd0, fill_way}, 0);
    check("arst_evict", {31'd0, vc_evict}, 0);
    check("arst_ack", {31'd0, binv_ack}, 0);
    check("arst_inst", inst, BUBBLE);
    check("arst_valid", {31'd0, inst_valid}, 0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      pc = p | 32'(i << 2);
      @(negedge clk);
      check("late_fill", {31'd0, fill_we}, 0);
      check("late_req", {31'd0, l2_if.l2_req_valid}, 0);
      check("late_valid", {31'd0, inst_valid}, 0);
      tick();
    end
    l2_if.l2_rsp_valid = 1'b0;
    do_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
